// File: rtl/router_pkg.sv
// Shared types for the clocked XY mesh router: port indices, FSM state
// encodings, header field positions and edge-link enables.
package router_pkg;

    localparam int NPORTS = 5;

    typedef enum logic [2:0] {
        PORT_L = 3'd0,
        PORT_E = 3'd1,
        PORT_W = 3'd2,
        PORT_N = 3'd3,
        PORT_S = 3'd4
    } port_e;

    typedef enum logic {
        I_IDLE = 1'b0,
        I_WAIT = 1'b1
    } in_state_e;

    typedef enum logic [1:0] {
        O_IDLE = 2'd0,
        O_REQ  = 2'd1,
        O_REL  = 2'd2
    } out_state_e;

    // MSB of the destination X field; the Y field sits directly below it.
    function automatic int hdr_dx_msb(input int flit_w);
        return flit_w - 1;
    endfunction

    function automatic int hdr_dy_msb(input int flit_w, input int coord_w);
        return flit_w - 1 - coord_w;
    endfunction

    // Links that point off the mesh are disabled on both directions.
    function automatic logic [NPORTS-1:0] port_enable(input int x, input int y,
                                                      input int max_x, input int max_y);
        logic [NPORTS-1:0] en;
        en = '1;
        if (x == max_x) en[PORT_E] = 1'b0;
        if (x == 0)     en[PORT_W] = 1'b0;
        if (y == max_y) en[PORT_N] = 1'b0;
        if (y == 0)     en[PORT_S] = 1'b0;
        return en;
    endfunction

    function automatic port_e rr_next(input port_e last, input int step);
        return port_e'(3'((int'(last) + step) % NPORTS));
    endfunction

endpackage

// File: rtl/flit_fifo.sv
// Count-based single-clock flit FIFO; head is visible combinationally on rdata_o.
module flit_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // NOTE: storage is deliberately not reset; count_q alone says which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mesh_xy_router.sv
// Clocked 5-port XY mesh router with per-input FIFOs and round-robin outputs.
// Optional per-output flit counters are built when ROUTER_STATS_EN is defined.
module mesh_xy_router
    import router_pkg::*;
#(
    parameter int n       = 32,
    parameter int COORD_W = 4,
    parameter int srcx    = 0,
    parameter int srcy    = 0,
    parameter int maxx    = 2,
    parameter int maxy    = 2,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NPORTS-1:0][n-1:0] in_data,
    input  logic [NPORTS-1:0]        in_req,
    output logic [NPORTS-1:0]        in_ack,
    output logic [NPORTS-1:0][n-1:0] out_data,
    output logic [NPORTS-1:0]        out_req,
    input  logic [NPORTS-1:0]        out_ack,
    output logic                     err_drop
`ifdef ROUTER_STATS_EN
    ,
    output logic [NPORTS-1:0][15:0]  stat_cnt
`endif
);

    localparam int                 DX_MSB  = hdr_dx_msb(n);
    localparam int                 DY_MSB  = hdr_dy_msb(n, COORD_W);
    localparam logic [COORD_W-1:0] SRC_X   = COORD_W'(srcx);
    localparam logic [COORD_W-1:0] SRC_Y   = COORD_W'(srcy);
    localparam logic [COORD_W-1:0] MAX_X   = COORD_W'(maxx);
    localparam logic [COORD_W-1:0] MAX_Y   = COORD_W'(maxy);
    localparam logic [NPORTS-1:0]  PORT_EN = port_enable(srcx, srcy, maxx, maxy);

    logic [NPORTS-1:0]        fifo_push;
    logic [NPORTS-1:0]        fifo_pop;
    logic [NPORTS-1:0]        fifo_full;
    logic [NPORTS-1:0]        fifo_empty;
    logic [NPORTS-1:0][n-1:0] fifo_head;
    logic [NPORTS-1:0]        can_accept;

    logic [NPORTS-1:0]        head_valid;
    logic [NPORTS-1:0]        head_drop;
    port_e                    head_route [NPORTS];

    in_state_e                in_state_q [NPORTS];
    in_state_e                in_state_d [NPORTS];
    out_state_e               out_state_q [NPORTS];
    out_state_e               out_state_d [NPORTS];
    port_e                    last_grant_q [NPORTS];
    logic [NPORTS-1:0]        gnt_valid;
    port_e                    gnt_idx [NPORTS];
    logic [NPORTS-1:0][n-1:0] out_data_q;
    logic                     err_drop_q;

    function automatic logic in_range(input logic [n-1:0] flit);
        return (flit[DX_MSB -: COORD_W] <= MAX_X) && (flit[DY_MSB -: COORD_W] <= MAX_Y);
    endfunction

    function automatic port_e xy_route(input logic [n-1:0] flit);
        logic [COORD_W-1:0] dx;
        logic [COORD_W-1:0] dy;
        dx = flit[DX_MSB -: COORD_W];
        dy = flit[DY_MSB -: COORD_W];
        if (dx > SRC_X) return PORT_E;
        if (dx < SRC_X) return PORT_W;
        if (dy > SRC_Y) return PORT_N;
        if (dy < SRC_Y) return PORT_S;
        return PORT_L;
    endfunction

    for (genvar i = 0; i < NPORTS; i++) begin : g_fifo
        flit_fifo #(
            .WIDTH (n),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst),
            .push_i  (fifo_push[i]),
            .wdata_i (in_data[i]),
            .pop_i   (fifo_pop[i]),
            .rdata_o (fifo_head[i]),
            .full_o  (fifo_full[i]),
            .empty_o (fifo_empty[i])
        );
    end

    assign can_accept = in_req & ~fifo_full & PORT_EN;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin : head_decode
        for (int i = 0; i < NPORTS; i++) begin
            head_valid[i] = !fifo_empty[i] && in_range(fifo_head[i]);
            head_drop[i]  = !fifo_empty[i] && !in_range(fifo_head[i]);
            head_route[i] = xy_route(fifo_head[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin : in_state_reg
        if (!rst) begin
            for (int i = 0; i < NPORTS; i++) in_state_q[i] <= I_IDLE;
        end else begin
            for (int i = 0; i < NPORTS; i++) in_state_q[i] <= in_state_d[i];
        end
    end

    always_comb begin : in_next
        for (int i = 0; i < NPORTS; i++) begin
            in_state_d[i] = in_state_q[i];
            unique case (in_state_q[i])
                I_IDLE:  if (can_accept[i]) in_state_d[i] = I_WAIT;
                I_WAIT:  if (!in_req[i])    in_state_d[i] = I_IDLE;
                default: in_state_d[i] = I_IDLE;
            endcase
        end
    end

    always_comb begin : in_out
        for (int i = 0; i < NPORTS; i++) begin
            fifo_push[i] = (in_state_q[i] == I_IDLE) && can_accept[i];
            in_ack[i]    = (in_state_q[i] == I_WAIT);
        end
    end

    // A granted head keeps its output busy until popped, so it cannot be granted twice.
    always_comb begin : arbitrate
        for (int o = 0; o < NPORTS; o++) begin
            gnt_valid[o] = 1'b0;
            gnt_idx[o]   = last_grant_q[o];
            for (int k = 1; k <= NPORTS; k++) begin
                port_e cand;
                cand = rr_next(last_grant_q[o], k);
                if (!gnt_valid[o] && PORT_EN[o] && out_state_q[o] == O_IDLE &&
                    head_valid[cand] && head_route[cand] == port_e'(o)) begin
                    gnt_valid[o] = 1'b1;
                    gnt_idx[o]   = cand;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin : out_state_reg
        if (!rst) begin
            for (int o = 0; o < NPORTS; o++) begin
                out_state_q[o]  <= O_IDLE;
                last_grant_q[o] <= PORT_L;
            end
            out_data_q <= '0;
            err_drop_q <= 1'b0;
        end else begin
            for (int o = 0; o < NPORTS; o++) begin
                out_state_q[o] <= out_state_d[o];
                if (gnt_valid[o]) begin
                    last_grant_q[o] <= gnt_idx[o];
                    out_data_q[o]   <= fifo_head[gnt_idx[o]];
                end
            end
            err_drop_q <= |head_drop;
        end
    end

    always_comb begin : out_next
        for (int o = 0; o < NPORTS; o++) begin
            out_state_d[o] = out_state_q[o];
            unique case (out_state_q[o])
                O_IDLE:  if (gnt_valid[o]) out_state_d[o] = O_REQ;
                O_REQ:   if (out_ack[o])   out_state_d[o] = O_REL;
                O_REL:   if (!out_ack[o])  out_state_d[o] = O_IDLE;
                default: out_state_d[o] = O_IDLE;
            endcase
        end
    end

    // last_grant_q doubles as the source of the flit being offered on each output.
    always_comb begin : out_out
        fifo_pop = head_drop;
        for (int o = 0; o < NPORTS; o++) begin
            out_req[o] = (out_state_q[o] == O_REQ);
            if (out_state_q[o] == O_REQ && out_ack[o]) fifo_pop[last_grant_q[o]] = 1'b1;
        end
    end

    assign out_data = out_data_q;
    assign err_drop = err_drop_q;

`ifdef ROUTER_STATS_EN
    logic [NPORTS-1:0][15:0] stat_cnt_q;

    always_ff @(posedge clk or negedge rst) begin : stats
        if (!rst) begin
            stat_cnt_q <= '0;
        end else begin
            for (int o = 0; o < NPORTS; o++) begin
                if (out_state_q[o] == O_REQ && out_ack[o] && stat_cnt_q[o] != 16'hFFFF)
                    stat_cnt_q[o] <= stat_cnt_q[o] + 16'd1;
            end
        end
    end

    assign stat_cnt = stat_cnt_q;
`endif

endmodule

// File: doc/mesh_xy_router.md
Name: mesh_xy_router

Overview:
- Clocked, parametrised 5-port mesh router: Local, East, West, North, South.
- Successor to the unclocked corner/edge/centre router variants: one module serves every mesh position.
- Per-input flit FIFOs of configurable depth, XY routing, round-robin output arbitration.
- 4-phase req/ack handshake on every link; links that fall off the mesh edge are disabled by the srcx/srcy/maxx/maxy parameters.

Parameters:
- n, 32, flit width in bits.
- COORD_W, 4, width of each destination coordinate field.
- srcx, 0, this router's X coordinate.
- srcy, 0, this router's Y coordinate.
- maxx, 2, largest X coordinate in the mesh (inclusive).
- maxy, 2, largest Y coordinate in the mesh (inclusive).
- DEPTH, 4, entries per input FIFO; power of two, at least 2.

Ports:
- clk  input  1  single clock for the router and all neighbours.
- rst  input  1  asynchronous, active-low reset.
- in_data  input  [5][n]  flit per input port; index 0 L, 1 E, 2 W, 3 N, 4 S.
- in_req  input  [5]  4-phase request per input.
- in_ack  output  [5]  4-phase acknowledge per input.
- out_data  output  [5][n]  flit per output port.
- out_req  output  [5]  4-phase request per output.
- out_ack  input  [5]  4-phase acknowledge per output.
- err_drop  output  1  one-cycle pulse when a flit is discarded.

Behaviour:
- Reset (rst=0, asynchronous): all FSMs go idle and all FIFOs empty.
- Reset values: in_ack=0, out_req=0, out_data=0, err_drop=0, round-robin pointers=0. Flits in flight are lost.
- All link signals are synchronous to clk. Every output is registered.
- Flit header fields:
  - dest x = data[n-1 -: COORD_W].
  - dest y = data[n-1-COORD_W -: COORD_W].
  - Flits are single-flit packets.
- Input FSM, one per port:
  - I_IDLE: when in_req=1 and the FIFO is not full, write the flit and set in_ack=1 at the same edge, then go to I_WAIT.
  - I_IDLE, FIFO full: in_ack stays 0 until space frees.
  - I_WAIT: when in_req=0, set in_ack=0 and go to I_IDLE.
- Routing of the FIFO head (XY):
  - dx>srcx goes E; dx<srcx goes W.
  - Otherwise dy>srcy goes N; dy<srcy goes S.
  - Otherwise the flit goes to L (loopback allowed).
- Out-of-range destination (dx>maxx or dy>maxy):
  - The head is popped without forwarding.
  - err_drop pulses for 1 cycle.
  - No out_req is raised.
- Edge ports: a port pointing off the mesh (E when srcx==maxx, W when srcx==0, N when srcy==maxy, S when srcy==0):
  - out_req is tied 0 and in_ack is tied 0.
  - Routing never selects it, because in-range destinations cannot point there.
- Output FSM, one per port:
  - O_IDLE: round-robin grant among the inputs whose head routes here. Search starts at last_grant+1 (mod 5). On the grant edge, register out_data from the head, set out_req=1, and go to O_REQ.
  - O_REQ: when out_ack=1, set out_req=0, pop the granted FIFO and go to O_REL.
  - O_REL: when out_ack=0, go to O_IDLE.
  - out_data holds stable from the grant edge until the next grant.
- Latency: a flit written at edge k can raise out_req at edge k+1.
- Pointer: last_grant updates on every grant.
- Simultaneous events:
  - A FIFO may push and pop in the same cycle.
  - Each head targets exactly one output, so no input is granted twice.
  - A granted head cannot be re-arbitrated by another output until it is popped.
- Flow control: a FIFO stays full while downstream holds out_ack low. Upstream then stalls with in_req=1 and in_ack=0.

Optional Feature:
ROUTER_STATS_EN:
- Defined: adds output port stat_cnt [5][16], one saturating flit counter per output. A counter increments on the O_REQ to O_REL transition and holds at 16'hFFFF. It is cleared by rst.
- Undefined: the port and the counters are absent; behaviour is otherwise identical.

Decomposition:
- router_pkg holds:
  - port index enum (PORT_L, PORT_E, PORT_W, PORT_N, PORT_S);
  - NPORTS=5;
  - input and output FSM state enums;
  - header field position helpers.
- Sub-module flit_fifo: n-bit by DEPTH storage, push/pop, full/empty, count-based. Instantiated 5 times.
- Arbitration and routing stay in the top module.

Test Plan:
- Cfg srcx=1, srcy=1, maxx=2, maxy=2, n=32, COORD_W=4, DEPTH=4.
- Local inject 0x2100_00AA (dest 2,1): in_ack[0] rises at edge k; out_req[1] rises at edge k+1 with out_data[1]=0x2100_00AA. out_ack[1] pulse completes the handshake and the FIFO empties.
- West inject 0x1100_0005 (dest 1,1): out_req[0] rises with out_data[0]=0x1100_0005.
- East and West inject the same cycle, both with dest (1,0) and routed S:
  - out_req[4] carries E's flit first (pointer 0, search starts at 1);
  - after the 4-phase completes, it carries W's flit;
  - no flit is lost.
- out_ack[1] held 0, W injects 5 flits all with dest 2,1:
  - 4 are acked;
  - the 5th sees in_ack[2] stay 0;
  - releasing out_ack drains all 5 in order, and the 5th is then accepted.
- Inject 0x3000_0000 (dx=3 > maxx) on N: err_drop pulses once, no out_req anywhere, in_ack completes normally.
- Assert rst=0 while out_req[1]=1: all req/ack go to 0 asynchronously; after release the FIFOs are empty and a fresh flit routes correctly.
